aidan_mcnay_prime_ctrl: RTL and testbench

//  Trial-division controller for the 16B prime detector. Accepts a number over a val/rdy

---
 rtl/aidan_mcnay_prime_ctrl_pkg.sv | 27 ++
 rtl/aidan_mcnay_prime_ctrl_rem_unit.sv | 75 +++++++
 rtl/aidan_mcnay_prime_ctrl.sv | 150 +++++++++++++++
 tb/tb_aidan_mcnay_prime_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aidan_mcnay_prime_ctrl_pkg.sv
// Shared definitions for the trial-division prime controller.
// Build option: AIDAN_MCNAY_PRIME_EVEN_SKIP_EN selects odd-only divisors
// (first divisor 3, two-cycle counter step, even numbers resolved at accept).
package aidan_mcnay_prime_ctrl_pkg;

    // Controller states; STEP2 is only reachable with even-skip enabled
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        DIV   = 3'd3,
        DONE  = 3'd4,
        STEP2 = 3'd5
    } state_t;

`ifdef AIDAN_MCNAY_PRIME_EVEN_SKIP_EN
    localparam int PRIME_FIRST_DIVISOR = 3;
`else
    localparam int PRIME_FIRST_DIVISOR = 2;
`endif

    // Cycles from rem-unit start to its done pulse: one quotient bit per cycle
    function automatic int rem_latency(input int nbits);
        return nbits;
    endfunction

endpackage

// File: rtl/aidan_mcnay_prime_ctrl_rem_unit.sv
// Sequential restoring remainder unit. Operands are captured on start; the
// first shift/subtract step happens on the capture edge so that done pulses
// exactly nbits cycles after start. Only the remainder is kept.
module aidan_mcnay_rem_unit
    import aidan_mcnay_prime_ctrl_pkg::*;
#(
    parameter int nbits = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [nbits-1:0] dividend,
    input  logic [nbits-1:0] divisor,
    output logic             done,
    output logic [nbits-1:0] rem
);

    localparam int CW = $clog2(nbits + 1);

    logic             busy;
    logic [CW-1:0]    cnt;
    logic [nbits-1:0] rem_q;
    logic [nbits-1:0] num_q;
    logic [nbits-1:0] dsr_q;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor when no borrow results.
    // Returns {next_remainder, next_dividend_shift}.
    function automatic logic [2*nbits-1:0] restore_step(
        input logic [nbits-1:0] r,
        input logic [nbits-1:0] q,
        input logic [nbits-1:0] d
    );
        logic [nbits:0]   sh;
        logic [nbits:0]   diff;
        logic [nbits-1:0] r_next;
        sh   = {r, q[nbits-1]};
        diff = sh - {1'b0, d};
        if (!diff[nbits])
            r_next = diff[nbits-1:0];
        else
            r_next = sh[nbits-1:0];
        return {r_next, q[nbits-2:0], 1'b0};
    endfunction

    // Step counter: loaded on start, done when it reaches zero while busy
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= CW'(rem_latency(nbits) - 1);
        end else if (busy) begin
            if (cnt == '0)
                busy <= 1'b0;
            else
                cnt <= cnt - 1'b1;
        end
    end

    // Remainder datapath: capture plus first step on start, then one step per cycle
    always_ff @(posedge clk) begin
        if (start) begin
            {rem_q, num_q} <= restore_step('0, dividend, divisor);
            dsr_q          <= divisor;
        end else if (busy && cnt != '0) begin
            {rem_q, num_q} <= restore_step(rem_q, num_q, dsr_q);
        end
    end

    assign done = busy && (cnt == '0);
    assign rem  = rem_q;

endmodule

// File: rtl/aidan_mcnay_prime_ctrl.sv
// Trial-division controller for the prime detector. Accepts n over a val/rdy
// request port, drives the upstream divisor counter (load / increment), checks
// each divisor d with the remainder unit until d*d > n or a divisor hits, and
// returns is_prime over a val/rdy response port.
// Build option: AIDAN_MCNAY_PRIME_EVEN_SKIP_EN -- even n resolved at accept,
// divisors start at 3 and advance by 2 (counter enable held for two cycles).
module aidan_mcnay_prime_ctrl
    import aidan_mcnay_prime_ctrl_pkg::*;
#(
    parameter int nbits = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_val,
    output logic             req_rdy,
    input  logic [nbits-1:0] req_num,
    output logic             resp_val,
    input  logic             resp_rdy,
    output logic             resp_is_prime,
    output logic [nbits-1:0] ctr_in_num,
    output logic             ctr_latch_val,
    output logic             ctr_en,
    input  logic [nbits-1:0] ctr_out_num
);

    state_t             state;
    logic [nbits-1:0]   n_q;
    logic [2*nbits-1:0] d_wide;
    logic [2*nbits-1:0] d_sq;
    logic               sq_gt_n;
    logic               rem_start;
    logic               rem_done;
    logic [nbits-1:0]   rem;
    logic               div_step;

    // d*d is formed at double width so it can never wrap
    assign d_wide  = {{nbits{1'b0}}, ctr_out_num};
    assign d_sq    = d_wide * d_wide;
    assign sq_gt_n = d_sq > {{nbits{1'b0}}, n_q};

    // Start a division whenever CHECK does not already prove primality
    assign rem_start = (state == CHECK) && !sq_gt_n;

    // Advance the divisor in the same cycle the non-zero remainder appears,
    // so the following CHECK already sees the next divisor
    assign div_step = (state == DIV) && rem_done && (rem != '0);

`ifdef AIDAN_MCNAY_PRIME_EVEN_SKIP_EN
    assign ctr_en = div_step || (state == STEP2);
`else
    assign ctr_en = div_step;
`endif

    assign ctr_in_num = nbits'(PRIME_FIRST_DIVISOR);

    aidan_mcnay_rem_unit #(
        .nbits (nbits)
    ) u_rem (
        .clk      (clk),
        .rst      (rst),
        .start    (rem_start),
        .dividend (n_q),
        .divisor  (ctr_out_num),
        .done     (rem_done),
        .rem      (rem)
    );

    // Control FSM with registered handshake, result and counter-load outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            req_rdy       <= 1'b1;
            resp_val      <= 1'b0;
            resp_is_prime <= 1'b0;
            ctr_latch_val <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_val && req_rdy) begin
                        n_q     <= req_num;
                        req_rdy <= 1'b0;
                        if (req_num < nbits'(2)) begin
                            state         <= DONE;
                            resp_val      <= 1'b1;
                            resp_is_prime <= 1'b0;
`ifdef AIDAN_MCNAY_PRIME_EVEN_SKIP_EN
                        end else if (req_num == nbits'(2)) begin
                            state         <= DONE;
                            resp_val      <= 1'b1;
                            resp_is_prime <= 1'b1;
                        end else if (!req_num[0]) begin
                            state         <= DONE;
                            resp_val      <= 1'b1;
                            resp_is_prime <= 1'b0;
`endif
                        end else begin
                            state         <= LOAD;
                            ctr_latch_val <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    ctr_latch_val <= 1'b0;
                    state         <= CHECK;
                end
                CHECK: begin
                    if (sq_gt_n) begin
                        state         <= DONE;
                        resp_val      <= 1'b1;
                        resp_is_prime <= 1'b1;
                    end else begin
                        state <= DIV;
                    end
                end
                DIV: begin
                    if (rem_done) begin
                        if (rem == '0) begin
                            state         <= DONE;
                            resp_val      <= 1'b1;
                            resp_is_prime <= 1'b0;
                        end else begin
`ifdef AIDAN_MCNAY_PRIME_EVEN_SKIP_EN
                            state <= STEP2;
`else
                            state <= CHECK;
`endif
                        end
                    end
                end
                STEP2: begin
                    state <= CHECK;
                end
                DONE: begin
                    if (resp_rdy) begin
                        state    <= IDLE;
                        resp_val <= 1'b0;
                        req_rdy  <= 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    req_rdy       <= 1'b1;
                    resp_val      <= 1'b0;
                    ctr_latch_val <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aidan_mcnay_prime_ctrl.sv
// Self-checking bench for aidan_mcnay_prime_ctrl with a behavioural divisor
// counter and a scoreboard of expected results, latencies and strobe counts.
module tb_aidan_mcnay_prime_ctrl;

    localparam int NB = 16;
`ifdef AIDAN_MCNAY_PRIME_EVEN_SKIP_EN
    localparam int EN_LEN = 2;
`else
    localparam int EN_LEN = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          req_val;
    logic          req_rdy;
    logic [NB-1:0] req_num;
    logic          resp_val;
    logic          resp_rdy;
    logic          resp_is_prime;
    logic [NB-1:0] ctr_in_num;
    logic          ctr_latch_val;
    logic          ctr_en;
    logic [NB-1:0] ctr_out_num;

    always #5 clk = ~clk;

    aidan_mcnay_prime_ctrl #(.nbits(NB)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_val       (req_val),
        .req_rdy       (req_rdy),
        .req_num       (req_num),
        .resp_val      (resp_val),
        .resp_rdy      (resp_rdy),
        .resp_is_prime (resp_is_prime),
        .ctr_in_num    (ctr_in_num),
        .ctr_latch_val (ctr_latch_val),
        .ctr_en        (ctr_en),
        .ctr_out_num   (ctr_out_num)
    );

    // Upstream divisor counter (no reset)
    logic [NB-1:0] ctr_q = '0;
    always @(posedge clk) begin
        if (ctr_latch_val) ctr_q <= ctr_in_num;
        else if (ctr_en)   ctr_q <= ctr_q + 1'b1;
    end
    assign ctr_out_num = ctr_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor
    int  latch_cycles = 0;
    int  en_cycles    = 0;
    int  en_pulses    = 0;
    int  overlap      = 0;
    logic en_prev     = 1'b0;
    always @(negedge clk) begin
        if (ctr_latch_val) latch_cycles++;
        if (ctr_en) en_cycles++;
        if (ctr_en && !en_prev) en_pulses++;
        if (ctr_en && ctr_latch_val) overlap++;
        en_prev = ctr_en;
    end

    int errors = 0;
    int checks = 0;

    typedef struct {
        int n;
        bit p;
        int lat;
        int latch;
        int en;
        int acc;
        int l0;
        int ep0;
        int ec0;
    } sb_t;
    sb_t sb[$];

    // Reference: plain trial division with the cycle cost of each step
    function automatic void model(input int n, output bit p, output int lat,
                                  output int latch, output int en);
        int d;
        int k;
        p = 1'b0; lat = 1; latch = 0; en = 0;
`ifdef AIDAN_MCNAY_PRIME_EVEN_SKIP_EN
        if (n < 2) return;
        if (n == 2) begin p = 1'b1; return; end
        if (n % 2 == 0) return;
        latch = 1; k = 0; d = 3;
        while (1) begin
            if (d * d > n) begin p = 1'b1; lat = 3 + k * 18; en = k; return; end
            k++;
            if (n % d == 0) begin p = 1'b0; lat = 1 + k * 18; en = k - 1; return; end
            d += 2;
        end
`else
        if (n < 2) return;
        latch = 1; k = 0; d = 2;
        while (1) begin
            if (d * d > n) begin p = 1'b1; lat = 3 + k * 17; en = k; return; end
            k++;
            if (n % d == 0) begin p = 1'b0; lat = 2 + k * 17; en = k - 1; return; end
            d++;
        end
`endif
    endfunction

    task automatic send(input int n);
        sb_t e;
        int  w;
        w = 0;
        @(negedge clk);
        while (!req_rdy && w < 100) begin @(negedge clk); w++; end
        checks++;
        if (!req_rdy) begin
            $display("FAIL send_rdy n=%0d: req_rdy=%b, required 1", n, req_rdy);
            errors++;
            return;
        end
        req_val = 1'b1;
        req_num = NB'(n);
        e.n = n;
        model(n, e.p, e.lat, e.latch, e.en);
        e.acc = cyc;
        e.l0  = latch_cycles;
        e.ep0 = en_pulses;
        e.ec0 = en_cycles;
        sb.push_back(e);
        @(negedge clk);
        req_val = 1'b0;
        req_num = NB'($urandom);
    endtask

    task automatic recv(input int hold);
        sb_t e;
        int  w;
        w = 0;
        while (!resp_val && w < 20000) begin @(negedge clk); w++; end
        if (sb.size() == 0) begin
            checks++;
            $display("FAIL sb_empty: response with nothing outstanding");
            errors++;
            return;
        end
        e = sb.pop_front();
        checks++;
        if (!resp_val) begin
            $display("FAIL resp_timeout n=%0d: resp_val=%b, required 1", e.n, resp_val);
            errors++;
            return;
        end
        checks++;
        if (resp_is_prime !== e.p)
            begin $display("FAIL is_prime n=%0d: got %b, required %b", e.n, resp_is_prime, e.p); errors++; end
        checks++;
        if (cyc - e.acc !== e.lat)
            begin $display("FAIL latency n=%0d: got %0d, required %0d", e.n, cyc - e.acc, e.lat); errors++; end
        for (int i = 0; i < hold; i++) begin
            req_val = 1'b1;
            req_num = NB'(5);
            @(negedge clk);
            checks++;
            if (resp_val !== 1'b1 || resp_is_prime !== e.p || req_rdy !== 1'b0) begin
                $display("FAIL hold n=%0d cyc%0d: val=%b prime=%b rdy=%b, required 1 %b 0", e.n, i, resp_val, resp_is_prime, req_rdy, e.p);
                errors++;
            end
        end
        req_val  = 1'b0;
        resp_rdy = 1'b1;
        @(negedge clk);
        resp_rdy = 1'b0;
        checks++;
        if (latch_cycles - e.l0 !== e.latch)
            begin $display("FAIL latch_count n=%0d: got %0d, required %0d", e.n, latch_cycles - e.l0, e.latch); errors++; end
        checks++;
        if (en_pulses - e.ep0 !== e.en)
            begin $display("FAIL en_pulses n=%0d: got %0d, required %0d", e.n, en_pulses - e.ep0, e.en); errors++; end
        checks++;
        if (en_cycles - e.ec0 !== e.en * EN_LEN)
            begin $display("FAIL en_cycles n=%0d: got %0d, required %0d", e.n, en_cycles - e.ec0, e.en * EN_LEN); errors++; end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (req_rdy !== 1'b1) begin $display("FAIL reset_req_rdy: got %b, required 1", req_rdy); errors++; end
        checks++;
        if (resp_val !== 1'b0) begin $display("FAIL reset_resp_val: got %b, required 0", resp_val); errors++; end
        checks++;
        if (resp_is_prime !== 1'b0) begin $display("FAIL reset_is_prime: got %b, required 0", resp_is_prime); errors++; end
        checks++;
        if (ctr_latch_val !== 1'b0) begin $display("FAIL reset_latch: got %b, required 0", ctr_latch_val); errors++; end
        checks++;
        if (ctr_en !== 1'b0) begin $display("FAIL reset_en: got %b, required 0", ctr_en); errors++; end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_small();
        send(0); recv(0);
        send(1); recv(0);
    endtask

    task automatic test_basic();
        int nums[10] = '{2, 3, 9, 7, 65521, 65535, 4, 25, 97, 221};
        foreach (nums[i]) begin
            send(nums[i]);
            recv(0);
        end
    endtask

    task automatic test_hold();
        int l0;
        send(9);
        recv(10);
        l0 = latch_cycles;
        repeat (3) @(negedge clk);
        checks++;
        if (resp_val !== 1'b0 || req_rdy !== 1'b1) begin
            $display("FAIL hold_after: val=%b rdy=%b, required 0 1", resp_val, req_rdy);
            errors++;
        end
        checks++;
        if (latch_cycles !== l0) begin
            $display("FAIL hold_ignored: latch strobes %0d, required %0d", latch_cycles, l0);
            errors++;
        end
    endtask

    task automatic test_reset_mid();
        send(65521);
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        sb.delete();
        checks++;
        if (resp_val !== 1'b0 || req_rdy !== 1'b1 || ctr_en !== 1'b0 || ctr_latch_val !== 1'b0) begin
            $display("FAIL reset_mid: val=%b rdy=%b en=%b latch=%b, required 0 1 0 0", resp_val, req_rdy, ctr_en, ctr_latch_val);
            errors++;
        end
        rst = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (resp_val !== 1'b0) begin
            $display("FAIL reset_mid_silent: resp_val=%b, required 0", resp_val);
            errors++;
        end
        send(7);
        recv(0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            send(int'($urandom_range(0, 3000)));
            recv(0);
        end
        checks++;
        if (overlap !== 0) begin
            $display("FAIL strobe_overlap: got %0d cycles, required 0", overlap);
            errors++;
        end
    endtask

    initial begin
        rst      = 1'b1;
        req_val  = 1'b0;
        req_num  = '0;
        resp_rdy = 1'b0;
        test_reset();
        test_small();
        test_basic();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
